// File: rtl/irq_pending_latch.sv
// irq_pending_latch
//   Request-collection stage ahead of the 8-to-3 priority encoder. It handles
//   the eight interrupt lines as follows:
//     - synchronises each asynchronous line;
//     - edge-detects each line and holds it as a sticky pending bit;
//     - applies a software mask;
//     - hands the masked vector plus a valid strobe to the encoder;
//     - clears the serviced bit when the consumer acknowledges.
//
//   Optional build macro:
//     IRQ_LEVEL_MODE_EN - pending follows the synchronised line levels;
//                         ack never clears pending and overrun is tied to 0.
//
//   Ports:
//     clk, rst        single clock, synchronous active-high reset
//     irq_in[7:0]     asynchronous request lines (rising edge = request)
//     mask_wr         mask write strobe
//     mask_wdata[7:0] new mask value
//     mask_q[7:0]     current mask register (1 = enabled)
//     pend_out[7:0]   pending & mask, feeds the encoder data input
//     pend_valid      encoder enable, high while in ASSERT
//     ack             consumer acknowledge pulse
//     ack_idx[2:0]    acknowledged index (encoder output)
//     ack_err         one-cycle pulse when ack names a non-pending line
//     overrun[7:0]    sticky per-line overrun flags
//     overrun_clr[7:0] write-1-to-clear for overrun
module irq_pending_latch #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  MASK_RST    = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] irq_in,
   input  logic       mask_wr,
   input  logic [7:0] mask_wdata,
   output logic [7:0] mask_q,
   output logic [7:0] pend_out,
   output logic       pend_valid,
   input  logic       ack,
   input  logic [2:0] ack_idx,
   output logic       ack_err,
   output logic [7:0] overrun,
   input  logic [7:0] overrun_clr
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ASSERT = 2'd1;
   localparam logic [1:0] ST_CLEAR  = 2'd2;

   logic [7:0] sync_q [SYNC_STAGES];
   logic [7:0] sync_d [SYNC_STAGES];
   logic [7:0] sync_last;

   logic [7:0] pending_q, pending_d;
   logic [7:0] overrun_q, overrun_d;
   logic [7:0] mask_d;
   logic [1:0] state_q, state_d;
   logic       ack_err_q, ack_err_d;

   logic [7:0] ack_onehot;
   logic       ack_hit;
   logic       ack_valid;
   logic       ack_bad;

   always_comb begin
      sync_d[0] = irq_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];

   assign pend_out   = pending_q & mask_q;
   assign pend_valid = (state_q == ST_ASSERT);
   assign ack_err    = ack_err_q;
   assign overrun    = overrun_q;

   assign ack_onehot = 8'h01 << ack_idx;
   assign ack_hit    = pend_out[ack_idx];
   assign ack_valid  = (state_q == ST_ASSERT) && ack && ack_hit;
   assign ack_bad    = (state_q == ST_ASSERT) && ack && !ack_hit;

`ifdef IRQ_LEVEL_MODE_EN
   logic unused_overrun_clr;
   assign unused_overrun_clr = ^overrun_clr;

   always_comb begin
      pending_d = sync_last;
      overrun_d = '0;
   end
`else
   logic [7:0] prev_q, prev_d;
   logic [7:0] edge_det;
   logic [7:0] ack_clr;

   assign edge_det = sync_last & ~prev_q;
   assign ack_clr  = ack_valid ? ack_onehot : '0;

   // A new edge is ORed in after the ack clear, so a request arriving in the
   // same cycle as its own acknowledge survives. That case is not an overrun,
   // because the older request was just serviced.
   always_comb begin
      prev_d    = sync_last;
      pending_d = (pending_q & ~ack_clr) | edge_det;
      overrun_d = (overrun_q & ~overrun_clr) | (edge_det & pending_q & ~ack_clr);
   end
`endif

   always_comb begin
      mask_d    = mask_wr ? mask_wdata : mask_q;
      ack_err_d = ack_bad;
      state_d   = state_q;
      case (state_q)
         ST_IDLE: begin
            if (|pend_out) state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (ack_valid)        state_d = ST_CLEAR;
            else if (~|pend_out)  state_d = ST_IDLE;
         end
         ST_CLEAR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         pending_q <= '0;
         overrun_q <= '0;
         mask_q    <= MASK_RST;
         state_q   <= ST_IDLE;
         ack_err_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         mask_q    <= mask_d;
         state_q   <= state_d;
         ack_err_q <= ack_err_d;
      end
   end

`ifndef IRQ_LEVEL_MODE_EN
   always_ff @(posedge clk) begin
      if (rst) prev_q <= '0;
      else     prev_q <= prev_d;
   end
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_in;
   logic       mask_wr;
   logic [7:0] mask_wdata;
   logic [7:0] mask_q;
   logic [7:0] pend_out;
   logic       pend_valid;
   logic       ack;
   logic [2:0] ack_idx;
   logic       ack_err;
   logic [7:0] overrun;
   logic [7:0] overrun_clr;

   irq_pending_latch #(.SYNC_STAGES(2), .MASK_RST(8'hFF)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in),
      .mask_wr    (mask_wr),
      .mask_wdata (mask_wdata),
      .mask_q     (mask_q),
      .pend_out   (pend_out),
      .pend_valid (pend_valid),
      .ack        (ack),
      .ack_idx    (ack_idx),
      .ack_err    (ack_err),
      .overrun    (overrun),
      .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [7:0] pend;
      logic       val;
      logic       err;
      logic [7:0] ovr;
      logic [7:0] mask;
   } exp_t;

   exp_t sb[$];

   int checks   = 0;
   int failures = 0;

   logic [7:0] e_pend;
   logic       e_val;
   logic       e_err;
   logic [7:0] e_ovr;
   logic [7:0] e_mask;

   // Queue the expected state for the coming edge, clock once, then compare
   // the DUT outputs 1 time unit after the edge.
   task automatic tick(input string tag);
      exp_t e;
      e.tag  = tag;
      e.pend = e_pend;
      e.val  = e_val;
      e.err  = e_err;
      e.ovr  = e_ovr;
      e.mask = e_mask;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      assert (pend_out === e.pend) else begin
         failures++;
         $error("FAIL %s pend_out got=%h exp=%h", e.tag, pend_out, e.pend);
      end
      checks++;
      assert (pend_valid === e.val) else begin
         failures++;
         $error("FAIL %s pend_valid got=%b exp=%b", e.tag, pend_valid, e.val);
      end
      checks++;
      assert (ack_err === e.err) else begin
         failures++;
         $error("FAIL %s ack_err got=%b exp=%b", e.tag, ack_err, e.err);
      end
      checks++;
      assert (overrun === e.ovr) else begin
         failures++;
         $error("FAIL %s overrun got=%h exp=%h", e.tag, overrun, e.ovr);
      end
      checks++;
      assert (mask_q === e.mask) else begin
         failures++;
         $error("FAIL %s mask_q got=%h exp=%h", e.tag, mask_q, e.mask);
      end
   endtask

   initial begin
      rst = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_wdata = '0;
      ack = 1'b0; ack_idx = '0; overrun_clr = '0;
      e_pend = '0; e_val = 1'b0; e_err = 1'b0; e_ovr = '0; e_mask = 8'hFF;

      // Reset then idle
      tick("rst0");
      tick("rst1");
      rst = 1'b0;
      tick("idle0");
      tick("idle1");

      // Single request on line 4
      irq_in = 8'h10;
      tick("s_e0");
      tick("s_e1");
      e_pend = 8'h10;
      tick("s_e2");
      e_val = 1'b1;
      tick("s_e3");
      ack = 1'b1; ack_idx = 3'd4;
      e_pend = '0; e_val = 1'b0;
      tick("s_clear");
      ack = 1'b0;
      tick("s_idle0");
      tick("s_idle1");
      irq_in = '0;
      tick("s_drop0");
      tick("s_drop1");
      tick("s_drop2");

      // Masked request is held until the mask opens
      mask_wr = 1'b1; mask_wdata = 8'h7F;
      e_mask = 8'h7F;
      tick("m_wr7f");
      mask_wr = 1'b0;
      irq_in = 8'h80;
      tick("m_e0");
      tick("m_e1");
      tick("m_e2");
      tick("m_e3");
      mask_wr = 1'b1; mask_wdata = 8'hFF;
      e_mask = 8'hFF; e_pend = 8'h80;
      tick("m_wrff");
      mask_wr = 1'b0;
      e_val = 1'b1;
      tick("m_valid");
      ack = 1'b1; ack_idx = 3'd7;
      e_pend = '0; e_val = 1'b0;
      tick("m_clear");
      ack = 1'b0;
      tick("m_idle");
      irq_in = '0;
      tick("m_drop0");
      tick("m_drop1");
      tick("m_drop2");

      // Two pending lines, bad ack then good ack
      irq_in = 8'h05;
      tick("b_e0");
      tick("b_e1");
      e_pend = 8'h05;
      tick("b_e2");
      e_val = 1'b1;
      tick("b_e3");
      ack = 1'b1; ack_idx = 3'd1;
      e_err = 1'b1;
      tick("b_bad");
      ack = 1'b0;
      e_err = 1'b0;
      tick("b_after");
      ack = 1'b1; ack_idx = 3'd2;
      e_pend = 8'h01; e_val = 1'b0;
      tick("b_clear");
      ack = 1'b0;
      tick("b_idle");
      e_val = 1'b1;
      tick("b_reassert");
      ack = 1'b1; ack_idx = 3'd0;
      e_pend = '0; e_val = 1'b0;
      tick("b_clear0");
      ack = 1'b0;
      tick("b_idle0");
      irq_in = '0;
      tick("b_drop0");
      tick("b_drop1");
      tick("b_drop2");

      // Overrun on line 3, then set-wins against a coinciding ack
      irq_in = 8'h08;
      tick("o_e0");
      tick("o_e1");
      e_pend = 8'h08;
      tick("o_e2");
      e_val = 1'b1;
      tick("o_e3");
      irq_in = '0;
      tick("o_low0");
      tick("o_low1");
      irq_in = 8'h08;
      tick("o_r0");
      tick("o_r1");
      e_ovr = 8'h08;
      tick("o_overrun");
      irq_in = '0;
      tick("o_low2");
      tick("o_low3");
      irq_in = 8'h08;
      tick("o_r2");
      tick("o_r3");
      ack = 1'b1; ack_idx = 3'd3;
      e_val = 1'b0;
      tick("o_setwins");
      ack = 1'b0;
      tick("o_idle");
      e_val = 1'b1;
      tick("o_reassert");
      overrun_clr = 8'h08;
      e_ovr = '0;
      tick("o_clr");
      overrun_clr = '0;
      tick("o_hold");

      // Reset in ASSERT with a would-be bad ack: no ack_err pulse
      rst = 1'b1; irq_in = '0;
      ack = 1'b1; ack_idx = 3'd0;
      e_pend = '0; e_val = 1'b0; e_err = 1'b0; e_ovr = '0; e_mask = 8'hFF;
      tick("r_mid");
      rst = 1'b0; ack = 1'b0;
      tick("r_after0");
      tick("r_after1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream request-collection stage for the 8-to-3 priority encoder.
- Synchronises 8 asynchronous interrupt lines, edge-detects them, and holds them as sticky pending bits.
- Applies a software mask and presents the masked vector plus a valid/enable to the encoder.
- Clears the serviced bit when the consumer acknowledges with the encoded index.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser per line. Minimum 2.
- MASK_RST, 8'hFF, reset value of the mask register (1 = enabled).

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous active-high reset
- irq_in  input  8  asynchronous request lines, rising edge = request
- mask_wr  input  1  mask write strobe
- mask_wdata  input  8  new mask value
- mask_q  output  8  current mask register
- pend_out  output  8  pending & mask; drives encoder data input
- pend_valid  output  1  drives encoder enable; high in ASSERT state
- ack  input  1  consumer acknowledge, single-cycle pulse
- ack_idx  input  3  index being acknowledged (encoder output)
- ack_err  output  1  one-cycle pulse on an invalid acknowledge
- overrun  output  8  sticky per-line overrun flags
- overrun_clr  input  8  write-1-to-clear for overrun

Behaviour:
- Reset: one clock is used; reset is synchronous and active-high. On the rst cycle:
  - sync/edge registers, pending, overrun, ack_err and state are cleared (state = IDLE).
  - mask_q is loaded with MASK_RST.
  - pend_out = 0 and pend_valid = 0 from the following cycle.
  - rst asserted mid-operation aborts any ASSERT with no ack_err pulse.
- Synchroniser: SYNC_STAGES flops per line, then a prev register.
  - edge[i] = sync_last[i] & ~prev[i].
- Latency: with SYNC_STAGES=2, an irq_in rise sampled at clock edge 0 sets pending at edge 2 and raises pend_valid at edge 3.
  - In general, pending is set at edge SYNC_STAGES and pend_valid at edge SYNC_STAGES+1.
- Pending set: edge[i] sets pending[i] regardless of the mask, so masked requests are held.
- pend_out: combinational pending & mask_q, with no further logic on the encoder path.
- mask_wr: updates mask_q on the next edge and takes effect on pend_out immediately after.
- FSM, 3 states:
  - IDLE: pend_valid=0. Go to ASSERT when |pend_out.
  - ASSERT: pend_valid=1.
    - On ack with pend_out[ack_idx]=1: clear pending[ack_idx] and go to CLEAR.
    - On ack with pend_out[ack_idx]=0: pulse ack_err, clear nothing, stay in ASSERT.
    - If pend_out becomes 0 with no ack (mask write): go to IDLE.
  - CLEAR: pend_valid=0 for exactly one cycle so the encoder output settles. Then go to IDLE.
- ack outside ASSERT: ignored, with no ack_err pulse.
- Simultaneous edge[i] and valid ack of i in the same cycle: set wins, so pending[i] stays 1. No overrun is flagged.
- Overrun:
  - edge[i] while pending[i]=1 and not being acked that cycle sets overrun[i].
  - overrun_clr[i] clears overrun[i].
  - If set and clear hit the same cycle, set wins.
- The pending vector never wraps or drops: a request is lost only as a counted overrun, i.e. it merges into the already-pending bit.

Optional Feature:
- Macro: IRQ_LEVEL_MODE_EN.
- Defined:
  - The edge detector is bypassed and pending[i] = sync_last[i] (level-sensitive).
  - A valid ack still moves ASSERT to CLEAR but does not clear pending; the source must drop its line.
  - overrun is tied to 0 and overrun_clr is ignored.
- Undefined: edge-triggered sticky behaviour as described above.

Test Plan:
- Reset then idle: rst for 2 cycles, irq_in=0 -> mask_q=8'hFF, pend_out=0, pend_valid=0, overrun=0.
- Single request: irq_in=8'h10 rising at edge 0 -> pend_out=8'h10 after edge 2, pend_valid=1 after edge 3. ack with idx=4 -> pend_valid=0 for 1 cycle, then pend_out=0 and the FSM returns to IDLE.
- Masked hold: mask_wdata=8'h7F written, irq_in[7] rises -> pend_out=0 and pend_valid stays 0. Write mask 8'hFF -> pend_out=8'h80 and pend_valid=1 next cycle.
- Multiple and bad ack: pending=8'h05, ack with idx=1 -> ack_err pulses 1 cycle and pend_out stays 8'h05. ack with idx=2 -> pend_out=8'h01 after CLEAR, then pend_valid reasserts.
- Overrun and set-wins: second rise on line 3 while pending[3]=1 -> overrun=8'h08. A rise coinciding with ack of idx=3 -> pending[3] stays 1 and overrun is unchanged. overrun_clr=8'h08 -> overrun=0.
- Reset mid-ASSERT: rst while pend_valid=1 -> next cycle pend_valid=0, pend_out=0, no ack_err pulse.
